// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer: renderer owns one 1024x16 bank while the
// composer scans and clears the other; banks swap on every line_render_start.
module sprite_line_buffer #(
   parameter int unsigned VISIBLE_W = 640
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        line_render_start,
   input  logic [9:0]  linebuf_rdidx,
   output logic [15:0] linebuf_rddata,
   input  logic [9:0]  linebuf_wridx,
   input  logic [15:0] linebuf_wrdata,
   input  logic        linebuf_wren,
   input  logic [9:0]  display_rdidx,
   input  logic        display_rden,
   output logic [7:0]  display_color,
   output logic [1:0]  display_z,
   output logic        display_valid,
   output logic        init_busy,
   output logic        sweep_overrun
);

   typedef enum logic [1:0] {INIT, IDLE, SWEEP} state_t;

   localparam logic [9:0] SWEEP_START = 10'(VISIBLE_W);

   state_t      state, state_d;
   logic        bank_sel, bank_sel_d;
   logic [9:0]  clr_idx, clr_idx_d;
   logic [9:0]  sweep_idx, sweep_idx_d;
   logic        overrun_d;
   logic        sweep_we;

   logic        clr_pend;
   logic [9:0]  clr_addr;
   logic        clr_bank;

   logic        we   [2];
   logic [9:0]  wa   [2];
   logic [15:0] wd   [2];

   logic [15:0] mem0 [1024];
   logic [15:0] mem1 [1024];

   logic [9:0]  disp_entry;
   logic        disp_fwd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= INIT;
         bank_sel      <= 1'b0;
         clr_idx       <= '0;
         sweep_idx     <= '0;
         sweep_overrun <= 1'b0;
      end else begin
         state         <= state_d;
         bank_sel      <= bank_sel_d;
         clr_idx       <= clr_idx_d;
         sweep_idx     <= sweep_idx_d;
         sweep_overrun <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state;
      bank_sel_d  = bank_sel;
      clr_idx_d   = clr_idx;
      sweep_idx_d = sweep_idx;
      overrun_d   = 1'b0;
      sweep_we    = 1'b0;
      case (state)
         INIT: begin
            clr_idx_d = clr_idx + 10'd1;
            if (clr_idx == '1) state_d = IDLE;
         end
         IDLE: begin
            if (line_render_start) begin
               bank_sel_d  = ~bank_sel;
               sweep_idx_d = SWEEP_START;
               state_d     = SWEEP;
            end
         end
         SWEEP: begin
            // a pending composer clear owns the display write port this cycle
            sweep_we = ~clr_pend;
            if (line_render_start) begin
               bank_sel_d  = ~bank_sel;
               sweep_idx_d = SWEEP_START;
               overrun_d   = 1'b1;
            end else if (sweep_we) begin
               sweep_idx_d = sweep_idx + 10'd1;
               if (sweep_idx == '1) state_d = IDLE;
            end
         end
         default: state_d = INIT;
      endcase
   end

   assign init_busy = (state == INIT);

   // clear targets the bank that was display at read time, even across a swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_pend <= 1'b0;
         clr_addr <= '0;
         clr_bank <= 1'b0;
      end else begin
         clr_pend <= display_rden && (state != INIT);
         clr_addr <= display_rdidx;
         clr_bank <= ~bank_sel;
      end
   end

   always_comb begin
      for (int unsigned b = 0; b < 2; b++) begin
         we[b] = 1'b0;
         wa[b] = '0;
         wd[b] = '0;
         if (state == INIT) begin
            we[b] = 1'b1;
            wa[b] = clr_idx;
         end else if (clr_pend && (clr_bank == 1'(b))) begin
            we[b] = 1'b1;
            wa[b] = clr_addr;
         end else if (bank_sel == 1'(b)) begin
            we[b] = linebuf_wren;
            wa[b] = linebuf_wridx;
            wd[b] = linebuf_wrdata;
         end else begin
            we[b] = sweep_we;
            wa[b] = sweep_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we[0]) mem0[wa[0]] <= wd[0];
   end

   always_ff @(posedge clk) begin
      if (we[1]) mem1[wa[1]] <= wd[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) linebuf_rddata <= '0;
      else        linebuf_rddata <= bank_sel ? mem1[linebuf_rdidx] : mem0[linebuf_rdidx];
   end

   assign disp_entry = bank_sel ? mem0[display_rdidx][9:0] : mem1[display_rdidx][9:0];
   assign disp_fwd   = clr_pend && (clr_addr == display_rdidx) && (clr_bank == ~bank_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_color <= '0;
         display_z     <= '0;
         display_valid <= 1'b0;
      end else begin
         display_valid <= display_rden && (state != INIT);
         if (display_rden && (state != INIT)) begin
            display_color <= disp_fwd ? '0 : disp_entry[7:0];
            display_z     <= disp_fwd ? '0 : disp_entry[9:8];
         end
      end
   end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed self-checking bench for sprite_line_buffer.
module tb_sprite_line_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        line_render_start;
   logic [9:0]  linebuf_rdidx;
   logic [15:0] linebuf_rddata;
   logic [9:0]  linebuf_wridx;
   logic [15:0] linebuf_wrdata;
   logic        linebuf_wren;
   logic [9:0]  display_rdidx;
   logic        display_rden;
   logic [7:0]  display_color;
   logic [1:0]  display_z;
   logic        display_valid;
   logic        init_busy;
   logic        sweep_overrun;

   int tests = 0;
   int fails = 0;

   sprite_line_buffer #(.VISIBLE_W(640)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .line_render_start (line_render_start),
      .linebuf_rdidx     (linebuf_rdidx),
      .linebuf_rddata    (linebuf_rddata),
      .linebuf_wridx     (linebuf_wridx),
      .linebuf_wrdata    (linebuf_wrdata),
      .linebuf_wren      (linebuf_wren),
      .display_rdidx     (display_rdidx),
      .display_rden      (display_rden),
      .display_color     (display_color),
      .display_z         (display_z),
      .display_valid     (display_valid),
      .init_busy         (init_busy),
      .sweep_overrun     (sweep_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rwrite(input logic [9:0] a, input logic [15:0] d);
      linebuf_wridx  = a;
      linebuf_wrdata = d;
      linebuf_wren   = 1'b1;
      tick();
      linebuf_wren   = 1'b0;
   endtask

   task automatic swap();
      line_render_start = 1'b1;
      tick();
      line_render_start = 1'b0;
   endtask

   task automatic test_reset();
      int bad_busy;
      int bad_valid;
      rst_n = 1'b0;
      line_render_start = 1'b0;
      linebuf_rdidx = '0;
      linebuf_wridx = '0;
      linebuf_wrdata = '0;
      linebuf_wren = 1'b0;
      display_rdidx = '0;
      display_rden = 1'b0;
      idle(3);
      tests++;
      if (linebuf_rddata !== 16'h0 || display_color !== 8'h0 || display_z !== 2'd0 ||
          display_valid !== 1'b0 || sweep_overrun !== 1'b0 || init_busy !== 1'b1) begin
         fails++;
         $display("FAIL reset_values: got rd=%h col=%h z=%0d v=%b ovr=%b busy=%b required 0 0 0 0 0 1",
                  linebuf_rddata, display_color, display_z, display_valid, sweep_overrun, init_busy);
      end
      rst_n = 1'b1;
      // hostile stimulus during INIT must have no effect
      display_rden = 1'b1;
      display_rdidx = 10'd3;
      linebuf_wren = 1'b1;
      linebuf_wridx = 10'd5;
      linebuf_wrdata = 16'hFFFF;
      line_render_start = 1'b1;
      bad_busy = 0;
      bad_valid = 0;
      for (int i = 1; i <= 1023; i++) begin
         tick();
         if (init_busy !== 1'b1) bad_busy++;
         if (display_valid !== 1'b0 || sweep_overrun !== 1'b0) bad_valid++;
      end
      display_rden = 1'b0;
      linebuf_wren = 1'b0;
      line_render_start = 1'b0;
      tests++;
      if (bad_busy != 0) begin
         fails++;
         $display("FAIL init_busy_hold: got %0d low cycles, required 0", bad_busy);
      end
      tests++;
      if (bad_valid != 0) begin
         fails++;
         $display("FAIL init_quiet: got %0d cycles with valid/overrun, required 0", bad_valid);
      end
      tick();
      tests++;
      if (init_busy !== 1'b0) begin
         fails++;
         $display("FAIL init_busy_fall: got %b required 0", init_busy);
      end
      for (int i = 0; i < 1024; i++) begin
         linebuf_rdidx = 10'(i);
         display_rdidx = 10'(i);
         display_rden = 1'b1;
         tick();
         tests++;
         if (linebuf_rddata !== 16'h0) begin
            fails++;
            $display("FAIL init_render_zero[%0d]: got %h required 0000", i, linebuf_rddata);
         end
         tests++;
         if (display_valid !== 1'b1 || display_color !== 8'h0 || display_z !== 2'd0) begin
            fails++;
            $display("FAIL init_display_zero[%0d]: got v=%b col=%h z=%0d required 1 00 0",
                     i, display_valid, display_color, display_z);
         end
      end
      display_rden = 1'b0;
      tick();
   endtask

   task automatic test_basic_swap();
      rwrite(10'd10, 16'h1305);
      linebuf_rdidx = 10'd10;
      tick();
      tests++;
      if (linebuf_rddata !== 16'h1305) begin
         fails++;
         $display("FAIL basic_render_read: got %h required 1305", linebuf_rddata);
      end
      idle(3);
      swap();
      display_rdidx = 10'd10;
      display_rden = 1'b1;
      tick();
      display_rden = 1'b0;
      tests++;
      if (display_valid !== 1'b1 || display_color !== 8'h05 || display_z !== 2'd3) begin
         fails++;
         $display("FAIL basic_display_read: got v=%b col=%h z=%0d required 1 05 3",
                  display_valid, display_color, display_z);
      end
      tick();
      tests++;
      if (display_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_valid_drop: got %b required 0", display_valid);
      end
      idle(400);
      swap();
      linebuf_rdidx = 10'd10;
      tick();
      tests++;
      if (linebuf_rddata !== 16'h0) begin
         fails++;
         $display("FAIL basic_cleared: got %h required 0000", linebuf_rddata);
      end
      idle(400);
   endtask

   task automatic test_render_rw();
      linebuf_rdidx = 10'd40;
      linebuf_wridx = 10'd40;
      linebuf_wrdata = 16'h0011;
      linebuf_wren = 1'b1;
      tick();
      linebuf_wren = 1'b0;
      tests++;
      if (linebuf_rddata !== 16'h0) begin
         fails++;
         $display("FAIL rw_same_cycle_old: got %h required 0000", linebuf_rddata);
      end
      tick();
      tests++;
      if (linebuf_rddata !== 16'h0011) begin
         fails++;
         $display("FAIL rw_new_data: got %h required 0011", linebuf_rddata);
      end
      rwrite(10'd40, 16'h0000);
      idle(3);
   endtask

   task automatic test_clear_forward();
      rwrite(10'd20, 16'h00AA);
      idle(3);
      swap();
      display_rdidx = 10'd20;
      display_rden = 1'b1;
      tick();
      tests++;
      if (display_valid !== 1'b1 || display_color !== 8'hAA || display_z !== 2'd0) begin
         fails++;
         $display("FAIL fwd_first_read: got v=%b col=%h z=%0d required 1 aa 0",
                  display_valid, display_color, display_z);
      end
      tick();
      display_rden = 1'b0;
      tests++;
      if (display_valid !== 1'b1 || display_color !== 8'h00) begin
         fails++;
         $display("FAIL fwd_second_read: got v=%b col=%h required 1 00", display_valid, display_color);
      end
      display_rden = 1'b1;
      tick();
      display_rden = 1'b0;
      tests++;
      if (display_color !== 8'h00) begin
         fails++;
         $display("FAIL fwd_stays_cleared: got %h required 00", display_color);
      end
      idle(400);
   endtask

   task automatic test_sweep();
      rwrite(10'd900, 16'h0155);
      linebuf_rdidx = 10'd900;
      tick();
      tests++;
      if (linebuf_rddata !== 16'h0155) begin
         fails++;
         $display("FAIL sweep_pre_read: got %h required 0155", linebuf_rddata);
      end
      idle(3);
      swap();
      idle(384);
      swap();
      tests++;
      if (sweep_overrun !== 1'b0) begin
         fails++;
         $display("FAIL sweep_no_overrun: got %b required 0", sweep_overrun);
      end
      linebuf_rdidx = 10'd900;
      tick();
      tests++;
      if (linebuf_rddata !== 16'h0) begin
         fails++;
         $display("FAIL sweep_cleared_900: got %h required 0000", linebuf_rddata);
      end
      idle(400);
   endtask

   task automatic test_overrun();
      rwrite(10'd1023, 16'h0BCD);
      idle(3);
      swap();
      idle(99);
      tests++;
      if (sweep_overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_early: got %b required 0", sweep_overrun);
      end
      linebuf_rdidx = 10'd1023;
      swap();
      tests++;
      if (sweep_overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_pulse: got %b required 1", sweep_overrun);
      end
      tick();
      tests++;
      if (sweep_overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_one_cycle: got %b required 0", sweep_overrun);
      end
      tests++;
      if (linebuf_rddata !== 16'h0BCD) begin
         fails++;
         $display("FAIL overrun_abandoned_bank: got %h required 0bcd", linebuf_rddata);
      end
      idle(383);
      swap();
      tests++;
      if (sweep_overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_restart_length: got %b required 0", sweep_overrun);
      end
      idle(400);
   endtask

   task automatic test_swap_collision();
      rwrite(10'd30, 16'h0277);
      idle(3);
      swap();
      idle(400);
      line_render_start = 1'b1;
      display_rden = 1'b1;
      display_rdidx = 10'd30;
      linebuf_rdidx = 10'd30;
      tick();
      line_render_start = 1'b0;
      display_rden = 1'b0;
      tests++;
      if (display_valid !== 1'b1 || display_color !== 8'h77 || display_z !== 2'd2) begin
         fails++;
         $display("FAIL collision_old_bank: got v=%b col=%h z=%0d required 1 77 2",
                  display_valid, display_color, display_z);
      end
      tests++;
      if (sweep_overrun !== 1'b0) begin
         fails++;
         $display("FAIL collision_no_overrun: got %b required 0", sweep_overrun);
      end
      idle(2);
      tests++;
      if (linebuf_rddata !== 16'h0) begin
         fails++;
         $display("FAIL collision_cleared_render: got %h required 0000", linebuf_rddata);
      end
      idle(400);
   endtask

   initial begin
      test_reset();
      test_basic_swap();
      test_render_rw();
      test_clear_forward();
      test_sweep();
      test_overrun();
      test_swap_collision();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sprite_line_buffer.md
# sprite_line_buffer

- Double-buffered sprite line buffer between the sprite renderer and the display composer.
- The renderer reads and writes one bank (the render bank) while the composer scans out the other bank (the display bank). The banks swap at every `line_render_start`.
- Every pixel the composer reads is cleared back to zero. A background sweep clears the off-screen tail of the display bank, so each bank is empty when it becomes the render bank again.

## Interface
- `VISIBLE_W`, default 640: number of on-screen entries the composer reads per line. Entries `VISIBLE_W`..1023 are cleared by the sweep.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `line_render_start` input 1: one-cycle pulse that swaps the banks.
- `linebuf_rdidx` input 10: renderer read address, render bank.
- `linebuf_rddata` output 16: renderer read data, valid one cycle after `linebuf_rdidx`.
- `linebuf_wridx` input 10: renderer write address, render bank.
- `linebuf_wrdata` input 16: renderer write data, format `{collision[3:0], 2'b0, z[1:0], color[7:0]}`.
- `linebuf_wren` input 1: renderer write enable.
- `display_rdidx` input 10: composer read address, display bank.
- `display_rden` input 1: composer read strobe. Each read also schedules a clear of the address read.
- `display_color` output 8: entry[7:0] of the last read.
- `display_z` output 2: entry[9:8] of the last read.
- `display_valid` output 1: high the cycle after `display_rden`.
- `init_busy` output 1: high while the post-reset clear is running.
- `sweep_overrun` output 1: one-cycle pulse when a swap arrives before the sweep has finished.

## Operation
- Storage: two banks, each 1024x16. Each bank has one synchronous read port and one write port.
- `bank_sel` selects the banks: `bank_sel`=0 means bank 0 is the render bank and bank 1 is the display bank.
- State machine states: INIT, IDLE, SWEEP.
- INIT:
  - Entered on reset.
  - Counter `clr_idx` runs 0..1023, writing 0 to both banks in the same cycle.
  - Renderer writes are ignored, `display_valid` stays 0 and `line_render_start` is ignored, so there is no toggle.
  - After `clr_idx`=1023 the block goes to IDLE.
- `line_render_start` outside INIT:
  - `bank_sel` toggles, taking effect the next cycle.
  - The state goes to SWEEP with `sweep_idx`=`VISIBLE_W`.
  - If the state was already SWEEP, `sweep_overrun` pulses and the sweep restarts on the new display bank.
- SWEEP:
  - Writes 0 to the display bank at `sweep_idx` and increments.
  - Goes to IDLE after writing index 1023.
  - Stalls for any cycle in which a display clear is pending.
- Display clear:
  - A read at cycle t latches the address and the display-bank identity.
  - It writes 0 to that bank and address at cycle t+1, even if a swap occurred at t.
- Display-bank write-port priority: display clear first, then sweep.
- Render-bank write port: carries renderer writes. A pending display clear landing in a bank that has just swapped to render takes priority, and the renderer write that cycle is dropped. The renderer cannot legitimately write within 3 cycles of `line_render_start`.
- Forwarding:
  - A display read of address A in the cycle when A's clear is being written returns 0.
  - A renderer read in the same cycle as a renderer write to the same address returns the old data.
- Address arithmetic is 10-bit with no wrap handling. Renderer indices ≥1024 cannot occur; a renderer wrap from 1023 to 0 is the renderer's responsibility.

## Timing
- Reset values:
  - Outputs: `linebuf_rddata`=0, `display_color`=0, `display_z`=0, `display_valid`=0, `sweep_overrun`=0, `init_busy`=1.
  - Internal: `bank_sel`=0, state INIT, `clr_idx`=0.
- INIT lasts exactly 1024 cycles after `rst_n` deasserts. `init_busy` falls in the cycle after the last INIT write.
- Renderer read latency is 1 cycle, with registered output.
- Display read latency is 1 cycle: `display_valid`, `display_color` and `display_z` are registered.
- A display read in the same cycle as `line_render_start` uses the old display bank.
- A renderer read or write in that same cycle uses the old render bank.
- Minimum sweep time is `1024-VISIBLE_W` cycles (384 by default), plus one cycle per stall.
- Reset asserted mid-operation: immediate return to INIT. Bank contents are considered invalid until INIT completes.

## Test plan
- Reset release: hold `init_busy`=1 for 1024 cycles, then read all 1024 entries of both banks. All read 0 and no `display_valid` is seen during INIT.
- Basic swap:
  - Renderer writes `16'h1305` at index 10.
  - Pulse `line_render_start`, then composer reads index 10.
  - `display_color`=`8'h05` and `display_z`=3 one cycle later.
  - Swap again: the renderer reads index 10 and sees 0.
- Clear forwarding: composer reads index 20 on two consecutive cycles after the entry was written as `16'h00AA`. The first read returns `8'hAA`, the second returns 0.
- Sweep: renderer writes index 900, then swap. Wait 384 cycles and swap again. The renderer reads 900 and sees 0; `sweep_overrun` stays 0.
- Overrun: issue a swap, then another swap 100 cycles later. `sweep_overrun` pulses once and the sweep restarts from index 640.
- Swap collision: composer reads in the same cycle as `line_render_start`. The data comes from the old display bank, and that address reads 0 in the new render bank.
